// File: rtl/cpu_pkg.sv
// Shared encodings for the multicycle control unit: FSM states, opcodes,
// datapath mux selects and the registered control-word layout.
`timescale 1ns/1ps
package cpu_pkg;

  // FSM states; BUSCA must stay at zero so a cleared register reads BUSCA
  typedef enum logic [3:0] {
    BUSCA   = 4'd0,
    BUSCA2  = 4'd1,
    DECOD   = 4'd2,
    EXEC_R  = 4'd3,
    EXEC_I  = 4'd4,
    LUI     = 4'd5,
    ADDR    = 4'd6,
    LOAD    = 4'd7,
    LOAD_WB = 4'd8,
    STORE   = 4'd9,
    BRANCH  = 4'd10,
    JAL     = 4'd11,
    WB      = 4'd12,
    EXCECAO = 4'd13
  } estado_t;

  // Instruction classes produced by the decoder
  typedef enum logic [2:0] {
    CL_R, CL_I, CL_LOAD, CL_STORE, CL_BRANCH, CL_LUI, CL_JAL, CL_INVALIDO
  } classe_t;

  // Opcodes
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  // funct3 / funct7 values that the unit accepts
  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_AND = 3'b111;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_SUB  = 7'b0100000;

  // ULA operation
  localparam logic [2:0] ULA_PASS = 3'b000;
  localparam logic [2:0] ULA_ADD  = 3'b001;
  localparam logic [2:0] ULA_SUB  = 3'b010;
  localparam logic [2:0] ULA_AND  = 3'b011;

  // ULA operand selects
  localparam logic [1:0] SRC_A_PC     = 2'b00;
  localparam logic [1:0] SRC_A_A      = 2'b01;
  localparam logic [1:0] SRC_A_PC_OLD = 2'b10;
  localparam logic [1:0] SRC_B_B      = 2'b00;
  localparam logic [1:0] SRC_B_4      = 2'b01;
  localparam logic [1:0] SRC_B_IMM    = 2'b10;
  localparam logic [1:0] SRC_B_IMM_SH = 2'b11;

  // PC source and write-back source
  localparam logic [1:0] PC_SRC_ULA     = 2'b00;
  localparam logic [1:0] PC_SRC_ULA_OUT = 2'b01;
  localparam logic [1:0] M2R_ULA_OUT    = 2'b00;
  localparam logic [1:0] M2R_MDR        = 2'b01;
  localparam logic [1:0] M2R_PC         = 2'b10;

  // Registered control word (everything except the branch pc_w term)
  typedef struct packed {
    logic       pc_w;
    logic [1:0] pc_src;
    logic       ir_w;
    logic       a_w;
    logic       b_w;
    logic       ula_out_w;
    logic       mdr_w;
    logic       mem_d_wr;
    logic       reg_w;
    logic [1:0] ula_src_a;
    logic [1:0] ula_src_b;
    logic [2:0] ula_sel;
    logic [1:0] mem_to_reg;
    logic       erro;
  } ctrl_t;

  // Moore output table: control word for a given state; sel_r is the
  // R-type operation picked by the decoder, used only in EXEC_R.
  function automatic ctrl_t saidas_estado(input estado_t s, input logic [2:0] sel_r);
    ctrl_t c;
    c = '0;
    case (s)
      BUSCA2: begin
        c.ir_w      = 1'b1;
        c.pc_w      = 1'b1;
        c.pc_src    = PC_SRC_ULA;
        c.ula_src_a = SRC_A_PC;
        c.ula_src_b = SRC_B_4;
        c.ula_sel   = ULA_ADD;
      end
      DECOD: begin
        c.a_w       = 1'b1;
        c.b_w       = 1'b1;
        c.ula_out_w = 1'b1;
        c.ula_src_a = SRC_A_PC_OLD;
        c.ula_src_b = SRC_B_IMM_SH;
        c.ula_sel   = ULA_ADD;
      end
      EXEC_R: begin
        c.ula_src_a = SRC_A_A;
        c.ula_src_b = SRC_B_B;
        c.ula_sel   = sel_r;
        c.ula_out_w = 1'b1;
      end
      EXEC_I, ADDR: begin
        c.ula_src_a = SRC_A_A;
        c.ula_src_b = SRC_B_IMM;
        c.ula_sel   = ULA_ADD;
        c.ula_out_w = 1'b1;
      end
      LUI: begin
        c.ula_src_b = SRC_B_IMM;
        c.ula_sel   = ULA_PASS;
        c.ula_out_w = 1'b1;
      end
      LOAD:    c.mdr_w = 1'b1;
      LOAD_WB: begin
        c.reg_w      = 1'b1;
        c.mem_to_reg = M2R_MDR;
      end
      STORE:   c.mem_d_wr = 1'b1;
      BRANCH: begin
        c.ula_src_a = SRC_A_A;
        c.ula_src_b = SRC_B_B;
        c.ula_sel   = ULA_SUB;
        c.pc_src    = PC_SRC_ULA_OUT;
      end
      JAL: begin
        c.reg_w      = 1'b1;
        c.mem_to_reg = M2R_PC;
        c.pc_w       = 1'b1;
        c.pc_src     = PC_SRC_ULA_OUT;
      end
      WB: begin
        c.reg_w      = 1'b1;
        c.mem_to_reg = M2R_ULA_OUT;
      end
      EXCECAO: c.erro = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/decod_instr.sv
// Combinational opcode/funct decoder: instruction class plus the
// funct-field validity flags each execution state needs.
`timescale 1ns/1ps
module decod_instr
  import cpu_pkg::*;
(
  input  logic [6:0] i_opcode,
  input  logic [2:0] i_funct3,
  input  logic [6:0] i_funct7,
  output classe_t    o_classe,
  output logic       o_r_valido,
  output logic [2:0] o_ula_sel_r,
  output logic       o_i_valido,
  output logic       o_mem_valido,
  output logic       o_br_valido,
  output logic       o_br_ne
);

  // Opcode to class, and R-type funct3/funct7 to ULA operation
  always_comb begin
    o_classe    = CL_INVALIDO;
    o_r_valido  = 1'b0;
    o_ula_sel_r = ULA_PASS;
    case (i_opcode)
      OP_R:      o_classe = CL_R;
      OP_I:      o_classe = CL_I;
      OP_LOAD:   o_classe = CL_LOAD;
      OP_STORE:  o_classe = CL_STORE;
      OP_BRANCH: o_classe = CL_BRANCH;
      OP_LUI:    o_classe = CL_LUI;
      OP_JAL:    o_classe = CL_JAL;
      default:   o_classe = CL_INVALIDO;
    endcase
    if (i_funct3 == F3_ADD && i_funct7 == F7_BASE) begin
      o_r_valido  = 1'b1;
      o_ula_sel_r = ULA_ADD;
    end else if (i_funct3 == F3_ADD && i_funct7 == F7_SUB) begin
      o_r_valido  = 1'b1;
      o_ula_sel_r = ULA_SUB;
    end else if (i_funct3 == F3_AND && i_funct7 == F7_BASE) begin
      o_r_valido  = 1'b1;
      o_ula_sel_r = ULA_AND;
    end
  end

  assign o_i_valido   = (i_funct3 == F3_ADD);
  assign o_mem_valido = (i_funct3 == F3_LD);
  assign o_br_valido  = (i_funct3 == F3_BEQ) || (i_funct3 == F3_BNE);
  assign o_br_ne      = (i_funct3 == F3_BNE);

endmodule

// File: rtl/unidade_controle.sv
// Multicycle control unit: Moore FSM with registered control outputs.
// The only combinational output term is pc_w in BRANCH, which follows
// the live ULA zero flag.
`timescale 1ns/1ps
module unidade_controle
  import cpu_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  input  logic       zero,
  output logic       pc_w,
  output logic [1:0] pc_src,
  output logic       ir_w,
  output logic       a_w,
  output logic       b_w,
  output logic       ula_out_w,
  output logic       mdr_w,
  output logic       mem_d_wr,
  output logic       reg_w,
  output logic [1:0] ula_src_a,
  output logic [1:0] ula_src_b,
  output logic [2:0] ula_sel,
  output logic [1:0] mem_to_reg,
  output logic [3:0] estado,
  output logic       erro
);

  classe_t    w_classe;
  logic       w_r_valido;
  logic [2:0] w_ula_sel_r;
  logic       w_i_valido;
  logic       w_mem_valido;
  logic       w_br_valido;
  logic       w_br_ne;
  logic       w_desvio;
  estado_t    w_prox;

  estado_t    r_estado;
  ctrl_t      r_ctrl;
  // Low until the first edge after reset release, so that first BUSCA
  // occupies a full clock period instead of a fraction of one.
  logic       r_partida;

  decod_instr u_decod (
    .i_opcode     (opcode),
    .i_funct3     (funct3),
    .i_funct7     (funct7),
    .o_classe     (w_classe),
    .o_r_valido   (w_r_valido),
    .o_ula_sel_r  (w_ula_sel_r),
    .o_i_valido   (w_i_valido),
    .o_mem_valido (w_mem_valido),
    .o_br_valido  (w_br_valido),
    .o_br_ne      (w_br_ne)
  );

  // Next-state selection
  always_comb begin
    w_prox = r_estado;
    if (!r_partida) begin
      w_prox = BUSCA;
    end else begin
      case (r_estado)
        BUSCA:  w_prox = BUSCA2;
        BUSCA2: w_prox = DECOD;
        DECOD: begin
          case (w_classe)
            CL_R:               w_prox = EXEC_R;
            CL_I:               w_prox = EXEC_I;
            CL_LOAD, CL_STORE:  w_prox = ADDR;
            CL_BRANCH:          w_prox = BRANCH;
            CL_LUI:             w_prox = LUI;
            CL_JAL:             w_prox = JAL;
            default:            w_prox = EXCECAO;
          endcase
        end
        EXEC_R: w_prox = w_r_valido ? WB : EXCECAO;
        EXEC_I: w_prox = w_i_valido ? WB : EXCECAO;
        LUI:    w_prox = WB;
        ADDR: begin
          if (!w_mem_valido)             w_prox = EXCECAO;
          else if (w_classe == CL_LOAD)  w_prox = LOAD;
          else                           w_prox = STORE;
        end
        LOAD:    w_prox = LOAD_WB;
        BRANCH:  w_prox = w_br_valido ? BUSCA : EXCECAO;
        LOAD_WB, STORE, JAL, WB: w_prox = BUSCA;
        EXCECAO: w_prox = EXCECAO;
        default: w_prox = EXCECAO;
      endcase
    end
  end

  // State register and control word for the state being entered
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_estado  <= BUSCA;
      r_ctrl    <= '0;
      r_partida <= 1'b0;
    end else begin
      r_partida <= 1'b1;
      r_estado  <= w_prox;
      r_ctrl    <= saidas_estado(w_prox, w_ula_sel_r);
    end
  end

  // Conditional branch: beq takes on zero, bne on not-zero
  assign w_desvio = (r_estado == BRANCH) && w_br_valido && (w_br_ne ? ~zero : zero);

  assign pc_w       = r_ctrl.pc_w | w_desvio;
  assign pc_src     = r_ctrl.pc_src;
  assign ir_w       = r_ctrl.ir_w;
  assign a_w        = r_ctrl.a_w;
  assign b_w        = r_ctrl.b_w;
  assign ula_out_w  = r_ctrl.ula_out_w;
  assign mdr_w      = r_ctrl.mdr_w;
  assign mem_d_wr   = r_ctrl.mem_d_wr;
  assign reg_w      = r_ctrl.reg_w;
  assign ula_src_a  = r_ctrl.ula_src_a;
  assign ula_src_b  = r_ctrl.ula_src_b;
  assign ula_sel    = r_ctrl.ula_sel;
  assign mem_to_reg = r_ctrl.mem_to_reg;
  assign estado     = r_estado;
  assign erro       = r_ctrl.erro;

endmodule
